// File: rtl/simon_decrypt_module_if.sv
// Serial host-side bus of the SIMON 32/64 decryption core: bit-serial command
// and data in, serial result out with its valid strobe and a busy flag.
interface simon_decrypt_module_if;
  logic       data_in;
  logic [1:0] data_rdy;
  logic       debug_port;
  logic       plain_out;
  logic       valid;
  logic       busy;

  modport master (output data_in, data_rdy, debug_port, input plain_out, valid, busy);
  modport slave  (input data_in, data_rdy, debug_port, output plain_out, valid, busy);
endinterface

// File: rtl/simon_decrypt_module.sv
// Bit-serial SIMON 32/64 decryption core: forward key expansion, 32 inverse rounds, serial readout.
// Optional macro SIMON_DEBUG_EN: debug_port=1 reads out {k31,k30} instead of plaintext.
module simon_decrypt_module #(
  parameter int ROUNDS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  simon_decrypt_module_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXPAND, DECRYPT, OUTPUT} state_t;

  localparam logic [15:0] C        = 16'hFFFC;
  localparam logic [61:0] Z0       = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [4:0]  EXP_LAST = 5'(ROUNDS - 5);
  localparam logic [4:0]  RND_LAST = 5'(ROUNDS - 1);

  state_t      state_reg, state_next;
  logic [31:0] blk_reg, out_sr_reg;
  logic [63:0] key_reg;
  logic [15:0] w3_reg, w2_reg, w1_reg, w0_reg;
  logic [4:0]  cnt_reg;

  function automatic logic [15:0] f_fn(input logic [15:0] v);
    return ({v[14:0], v[15]} & {v[7:0], v[15:8]}) ^ {v[13:0], v[15:14]};
  endfunction

  function automatic logic [15:0] tmp_fn(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] t;
    t = {b[2:0], b[15:3]} ^ a;
    return t ^ {t[0], t[15:1]};
  endfunction

  // z0[0] is the leftmost character of the sequence, i.e. the MSB of Z0.
  function automatic logic z_bit(input logic [4:0] i);
    return Z0[6'd61 - {1'b0, i}];
  endfunction

  logic [15:0] knew, kprev, y_new;
  logic [31:0] blk_next, out_src;

  assign knew     = w0_reg ^ C ^ {15'd0, z_bit(cnt_reg)} ^ tmp_fn(w1_reg, w3_reg);
  assign kprev    = w3_reg ^ C ^ {15'd0, z_bit(cnt_reg - 5'd4)} ^ tmp_fn(w0_reg, w2_reg);
  assign y_new    = blk_reg[31:16] ^ f_fn(blk_reg[15:0]) ^ w3_reg;
  assign blk_next = {blk_reg[15:0], y_new};

`ifdef SIMON_DEBUG_EN
  logic        dbg_sel_reg;
  logic [31:0] dbg_key_reg;
  assign out_src = dbg_sel_reg ? dbg_key_reg : blk_next;
`else
  logic unused_debug;
  assign unused_debug = bus.debug_port;
  assign out_src      = blk_next;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    bus.busy      = 1'b0;
    bus.valid     = 1'b0;
    bus.plain_out = 1'b0;
    case (state_reg)
      IDLE:    if (bus.data_rdy == 2'd3) state_next = EXPAND;
      EXPAND: begin
        bus.busy = 1'b1;
        if (cnt_reg == EXP_LAST) state_next = DECRYPT;
      end
      DECRYPT: begin
        bus.busy = 1'b1;
        if (cnt_reg == 5'd0) state_next = OUTPUT;
      end
      OUTPUT: begin
        bus.valid     = 1'b1;
        bus.plain_out = out_sr_reg[31];
        if (cnt_reg == 5'd0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blk_reg    <= '0;
      key_reg    <= '0;
      out_sr_reg <= '0;
      w3_reg     <= '0;
      w2_reg     <= '0;
      w1_reg     <= '0;
      w0_reg     <= '0;
      cnt_reg    <= '0;
`ifdef SIMON_DEBUG_EN
      dbg_sel_reg <= 1'b0;
      dbg_key_reg <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          case (bus.data_rdy)
            2'd1: blk_reg <= {blk_reg[30:0], bus.data_in};
            2'd2: key_reg <= {key_reg[62:0], bus.data_in};
            2'd3: begin
              w3_reg  <= key_reg[63:48];
              w2_reg  <= key_reg[47:32];
              w1_reg  <= key_reg[31:16];
              w0_reg  <= key_reg[15:0];
              cnt_reg <= 5'd0;
`ifdef SIMON_DEBUG_EN
              dbg_sel_reg <= bus.debug_port;
`endif
            end
            default: ;
          endcase
        end
        EXPAND: begin
          w0_reg  <= w1_reg;
          w1_reg  <= w2_reg;
          w2_reg  <= w3_reg;
          w3_reg  <= knew;
          cnt_reg <= cnt_reg + 5'd1;
          if (cnt_reg == EXP_LAST) begin
            cnt_reg <= RND_LAST;
`ifdef SIMON_DEBUG_EN
            dbg_key_reg <= {knew, w3_reg};
`endif
          end
        end
        DECRYPT: begin
          blk_reg <= blk_next;
          // Walk the schedule backwards; the last rounds no longer need a new key.
          w3_reg  <= w2_reg;
          w2_reg  <= w1_reg;
          w1_reg  <= w0_reg;
          w0_reg  <= (cnt_reg >= 5'd4) ? kprev : 16'd0;
          cnt_reg <= cnt_reg - 5'd1;
          if (cnt_reg == 5'd0) out_sr_reg <= out_src;
        end
        OUTPUT: begin
          out_sr_reg <= {out_sr_reg[30:0], 1'b0};
          cnt_reg    <= cnt_reg - 5'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_simon_decrypt_module.sv
// Self-checking bench for simon_decrypt_module against a textbook SIMON 32/64 model.
module tb_simon_decrypt_module;
  logic clk   = 1'b0;
  logic reset = 1'b0;

  simon_decrypt_module_if bus ();

  simon_decrypt_module #(.ROUNDS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  localparam logic [63:0] STD_KEY = 64'h1918111009080100;
  localparam logic [31:0] STD_CT  = 32'hC69BE9BB;
  localparam logic [31:0] STD_PT  = 32'h65656877;

  string       zseq = "11111010001001010110000111001101111101000100101011000011100110";
  logic [15:0] ks [0:31];
  logic [31:0] got;
  int          busy_cnt, valid_cnt, first_valid;
  bit          done;

  function automatic logic [15:0] rotl(input logic [15:0] v, input int n);
    return (v << n) | (v >> (16 - n));
  endfunction

  function automatic logic [15:0] rotr(input logic [15:0] v, input int n);
    return (v >> n) | (v << (16 - n));
  endfunction

  function automatic logic [15:0] rf(input logic [15:0] v);
    return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
  endfunction

  task automatic make_schedule(input logic [63:0] key);
    logic [15:0] t;
    for (int i = 0; i < 4; i++) ks[i] = key[16*i +: 16];
    for (int i = 0; i < 28; i++) begin
      t = rotr(ks[i+3], 3) ^ ks[i+1];
      t = t ^ rotr(t, 1);
      ks[i+4] = ~ks[i] ^ t ^ 16'(zseq.getc(i) == "1") ^ 16'd3;
    end
  endtask

  function automatic logic [31:0] model_enc(input logic [31:0] p);
    logic [15:0] x, y, t;
    x = p[31:16]; y = p[15:0];
    for (int r = 0; r < 32; r++) begin
      t = x; x = y ^ rf(x) ^ ks[r]; y = t;
    end
    return {x, y};
  endfunction

  function automatic logic [31:0] model_dec(input logic [31:0] c);
    logic [15:0] x, y, t;
    x = c[31:16]; y = c[15:0];
    for (int r = 31; r >= 0; r--) begin
      t = y; y = x ^ rf(y) ^ ks[r]; x = t;
    end
    return {x, y};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_bits(input logic [63:0] v, input int n, input logic [1:0] cmd);
    for (int i = n - 1; i >= 0; i--) begin
      bus.data_rdy = cmd;
      bus.data_in  = v[i];
      @(negedge clk);
    end
    bus.data_rdy = 2'd0;
  endtask

  // Issues a decrypt command from a negedge and collects the serial result.
  // Returns on the negedge just after the last valid bit, so a follow-up command can go out at once.
  task automatic run_decrypt(input bit dbg, input bit gate);
    bit seen;
    bus.data_rdy   = 2'd3;
    bus.debug_port = dbg;
    @(negedge clk);
    busy_cnt = 0; valid_cnt = 0; first_valid = 0; got = '0; seen = 0; done = 0;
    for (int idx = 1; idx <= 200 && !done; idx++) begin
      if (bus.busy) busy_cnt++;
      if (bus.valid) begin
        if (!seen) first_valid = idx;
        seen = 1;
        valid_cnt++;
        got = {got[30:0], bus.plain_out};
      end else if (seen) begin
        done = 1;
      end
      if (!done) begin
        bus.data_rdy   = gate ? 2'($urandom_range(1, 2)) : 2'd0;
        bus.data_in    = 1'($urandom);
        bus.debug_port = 1'($urandom);
        @(negedge clk);
      end
    end
    bus.data_rdy = 2'd0;
    check("complete", 64'(done), 64'd1);
    $display("txn decrypt dbg=%0d gate=%0d result=%h busy=%0d valid=%0d first_valid=%0d",
             dbg, gate, got, busy_cnt, valid_cnt, first_valid);
  endtask

  task automatic load_std();
    load_bits(STD_KEY, 64, 2'd2);
    load_bits({24'd0, 8'($urandom), STD_CT}, 40, 2'd1);
  endtask

  initial begin
    logic [63:0] rk;
    logic [31:0] rp, rc, exp;
    bus.data_in = 0; bus.data_rdy = 0; bus.debug_port = 0;

    repeat (3) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_valid", 64'(bus.valid), 64'd0);
    check("reset_plain_out", 64'(bus.plain_out), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    make_schedule(64'd0);
    run_decrypt(0, 0);
    check("zero_decrypt", 64'(got), 64'(model_dec(32'd0)));

    make_schedule(STD_KEY);
    check("model_std_enc", 64'(model_enc(STD_PT)), 64'(STD_CT));
    load_std();
    run_decrypt(0, 0);
    check("std_plain", 64'(got), 64'(STD_PT));
    check("std_busy_cycles", 64'(busy_cnt), 64'd60);
    check("std_valid_cycles", 64'(valid_cnt), 64'd32);
    check("std_first_valid", 64'(first_valid), 64'd61);

    load_std();
    run_decrypt(0, 1);
    check("gated_plain", 64'(got), 64'(STD_PT));
    run_decrypt(0, 0);
    check("back_to_back", 64'(got), 64'(model_dec(STD_PT)));
    check("b2b_busy_cycles", 64'(busy_cnt), 64'd60);

    for (int n = 0; n < 8; n++) begin
      rk = {$urandom, $urandom};
      rp = $urandom;
      make_schedule(rk);
      rc = model_enc(rp);
      load_bits(rk, 64, 2'd2);
      load_bits(64'(rc), 32, 2'd1);
      run_decrypt(0, 0);
      check($sformatf("round_trip_%0d", n), 64'(got), 64'(rp));
    end

    make_schedule(STD_KEY);
    load_std();
    bus.data_rdy = 2'd3;
    @(negedge clk);
    bus.data_rdy = 2'd0;
    repeat (57) @(negedge clk);
    check("abort_busy_before", 64'(bus.busy), 64'd1);
    reset = 1'b0;
    #1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_valid", 64'(bus.valid), 64'd0);
    $display("txn reset_abort busy=%0d valid=%0d", bus.busy, bus.valid);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    load_std();
    run_decrypt(0, 0);
    check("after_abort_plain", 64'(got), 64'(STD_PT));

    load_std();
    run_decrypt(1, 0);
`ifdef SIMON_DEBUG_EN
    exp = {ks[31], ks[30]};
`else
    exp = STD_PT;
`endif
    check("debug_readout", 64'(got), 64'(exp));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
